// File: rtl/rmii_pkg.sv
// Shared constants for the RMII receive deframer: FSM state codes, line dibits,
// CRC-32 constants and error codes.
package rmii_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT_IDLE = 3'd0;
  localparam state_t ST_IDLE      = 3'd1;
  localparam state_t ST_PREAMBLE  = 3'd2;
  localparam state_t ST_DATA      = 3'd3;
  localparam state_t ST_DROP      = 3'd4;

  localparam logic [1:0] PRE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT = 2'b11;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_CRC   = 2'b01;
  localparam logic [1:0] ERR_LEN   = 2'b10;
  localparam logic [1:0] ERR_ALIGN = 2'b11;

  // One serial CRC step, MSB-first register fed with line-order bits.
  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic d);
    crc32_bit = {crc[30:0], 1'b0} ^ ((crc[31] ^ d) ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/rmii_rx_deframer_if.sv
// PHY-side RMII receive pins plus the byte-stream output towards the MAC consumer.
interface rmii_rx_deframer_if;

  logic       CRS_DV;
  logic       RX0;
  logic       RX1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_err;
  logic [1:0] rx_err_code;
  logic       frame_ok;

  modport master (
    input  CRS_DV, RX0, RX1,
    output rx_data, rx_valid, rx_last, rx_err, rx_err_code, frame_ok
  );

  modport slave (
    output CRS_DV, RX0, RX1,
    input  rx_data, rx_valid, rx_last, rx_err, rx_err_code, frame_ok
  );

endinterface

// File: rtl/rmii_crc32_dibit.sv
// CRC-32 accumulator advancing two bits per clock; dibit[0] is the earlier bit on the wire.
module rmii_crc32_dibit
  import rmii_pkg::*;
(
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = '1;
    end else if (en) begin
      crc_d = crc32_bit(crc32_bit(crc_q, dibit[0]), dibit[1]);
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      crc_q <= '1;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/rmii_rx_deframer.sv
// RMII receive deframer: preamble/SFD strip, dibit-to-byte assembly, one-byte holdback
// for rx_last tagging. FCS checking is built only with RMII_RX_CRC_CHECK_EN defined.
module rmii_rx_deframer
  import rmii_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int MIN_PREAMBLE    = 4
) (
  input logic                clk_50MHz,
  input logic                rst,
  rmii_rx_deframer_if.master rx_if
);

  localparam int CNT_W = $clog2(MAX_FRAME_BYTES + 2);
  localparam int PRE_W = $clog2(MIN_PREAMBLE + 1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_FRAME_BYTES + 1);
  localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(MIN_PREAMBLE);

  logic [1:0]       dibit;
  logic             eof;
  state_t           state_q, state_d;
  logic             crs_low_q, crs_low_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [1:0]       dibit_cnt_q, dibit_cnt_d;
  logic [5:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic             ok_q, ok_d;

  assign dibit = {rx_if.RX1, rx_if.RX0};
  // Second consecutive low clock of CRS_DV; a single low clock is only a carrier toggle.
  assign eof   = !rx_if.CRS_DV && crs_low_q;

`ifdef RMII_RX_CRC_CHECK_EN
  logic [31:0] crc_value;

  rmii_crc32_dibit u_crc (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .init      (state_q == ST_IDLE),
    .en        ((state_q == ST_DATA) && rx_if.CRS_DV),
    .dibit     (dibit),
    .crc       (crc_value)
  );
`endif

  always_comb begin
    state_d     = state_q;
    crs_low_d   = !rx_if.CRS_DV;
    pre_cnt_d   = pre_cnt_q;
    dibit_cnt_d = dibit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    byte_cnt_d  = byte_cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = ERR_NONE;
    ok_d        = 1'b0;

    case (state_q)
      ST_WAIT_IDLE: begin
        if (eof) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        dibit_cnt_d = '0;
        byte_cnt_d  = '0;
        hold_vld_d  = 1'b0;
        if (rx_if.CRS_DV && dibit == PRE_DIBIT) begin
          state_d   = ST_PREAMBLE;
          pre_cnt_d = PRE_W'(1);
        end
      end
      ST_PREAMBLE: begin
        if (rx_if.CRS_DV && dibit == PRE_DIBIT) begin
          if (pre_cnt_q != PRE_MIN) pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end else if (rx_if.CRS_DV && dibit == SFD_DIBIT && pre_cnt_q == PRE_MIN) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_if.CRS_DV) begin
          shift_d     = {dibit, shift_q[5:2]};
          dibit_cnt_d = dibit_cnt_q + 2'd1;
          if (dibit_cnt_q == 2'd3) begin
            // Release the previously held byte; the new one waits to learn if it is last.
            valid_d    = hold_vld_q;
            data_d     = hold_q;
            hold_d     = {dibit, shift_q};
            hold_vld_d = 1'b1;
            if (byte_cnt_q != CNT_SAT) byte_cnt_d = byte_cnt_q + CNT_W'(1);
            if (byte_cnt_q == CNT_MAX) begin
              last_d  = 1'b1;
              err_d   = 1'b1;
              code_d  = ERR_LEN;
              state_d = ST_DROP;
            end
          end
        end else if (eof) begin
          state_d = ST_IDLE;
          if (hold_vld_q) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            data_d  = hold_q;
            if (dibit_cnt_q != 2'd0) begin
              code_d = ERR_ALIGN;
            end else if (byte_cnt_q < CNT_MIN) begin
              code_d = ERR_LEN;
`ifdef RMII_RX_CRC_CHECK_EN
            end else if (crc_value != CRC_RESIDUE) begin
              code_d = ERR_CRC;
`endif
            end
            err_d = (code_d != ERR_NONE);
            ok_d  = (code_d == ERR_NONE);
          end
        end
      end
      ST_DROP: begin
        if (eof) state_d = ST_WAIT_IDLE;
      end
      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= ST_WAIT_IDLE;
      crs_low_q   <= 1'b0;
      pre_cnt_q   <= '0;
      dibit_cnt_q <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      crs_low_q   <= crs_low_d;
      pre_cnt_q   <= pre_cnt_d;
      dibit_cnt_q <= dibit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      byte_cnt_q  <= byte_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
      code_q      <= code_d;
      ok_q        <= ok_d;
    end
  end

  assign rx_if.rx_data     = data_q;
  assign rx_if.rx_valid    = valid_q;
  assign rx_if.rx_last     = last_q;
  assign rx_if.rx_err      = err_q;
  assign rx_if.rx_err_code = code_q;
  assign rx_if.frame_ok    = ok_q;

endmodule

// File: tb/tb_rmii_rx_deframer.sv
// Directed bench for rmii_rx_deframer: builds Ethernet frames with a reference FCS,
// streams them as dibits and scores the received byte stream and end-of-frame flags.
module tb_rmii_rx_deframer;

  logic clk_50MHz = 1'b0;
  logic rst;
  always #10 clk_50MHz = ~clk_50MHz;

  rmii_rx_deframer_if rx_if ();

  rmii_rx_deframer dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .rx_if     (rx_if)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] frm[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         last_cnt, last_beat, ok_cnt, bad_cnt;
  logic       last_err;
  logic [1:0] last_code;
  logic       clr = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk_50MHz) begin
    if (clr) begin
      got_q.delete();
      last_cnt  = 0;
      last_beat = 0;
      ok_cnt    = 0;
      bad_cnt   = 0;
      last_err  = 1'b0;
      last_code = 2'b00;
    end else if (rst === 1'b0) begin
      if (rx_if.rx_valid) got_q.push_back(rx_if.rx_data);
      if (rx_if.rx_valid && rx_if.rx_last) begin
        last_cnt++;
        last_beat = got_q.size();
        last_err  = rx_if.rx_err;
        last_code = rx_if.rx_err_code;
      end
      if (rx_if.frame_ok) ok_cnt++;
      if ((!rx_if.rx_last && (rx_if.rx_err || rx_if.rx_err_code != 2'b00)) ||
          (rx_if.frame_ok != (rx_if.rx_valid && rx_if.rx_last && !rx_if.rx_err)))
        bad_cnt++;
    end
  end

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk_50MHz);
    #1 clr = 1'b0;
  endtask

  task automatic drive(input logic crs, input logic [1:0] d);
    @(posedge clk_50MHz);
    #1;
    rx_if.CRS_DV = crs;
    rx_if.RX0    = d[0];
    rx_if.RX1    = d[1];
  endtask

  // Payload plus reflected CRC-32 FCS, sent least significant byte first.
  task automatic build_frame(input int n_payload, input int seed);
    logic [31:0] c;
    frm.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n_payload; i++) begin
      frm.push_back(8'((i * 13 + seed) & 255));
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic send_frame(input int n_pre, input int toggle_at, input int n_extra, input int gap);
    logic [7:0] b;
    for (int i = 0; i < n_pre; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      for (int k = 0; k < 4; k++) begin
        if (i == toggle_at && k == 2) drive(1'b0, 2'b00);
        drive(1'b1, b[2*k +: 2]);
      end
    end
    for (int i = 0; i < n_extra; i++) drive(1'b1, 2'b10);
    for (int i = 0; i < gap; i++) drive(1'b0, 2'b00);
  endtask

  task automatic check_frame(input string tag, input int n, input int exp_last,
                             input logic exp_err, input logic [1:0] exp_code, input int exp_ok);
    int mism;
    mism = 0;
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00);
    for (int i = 0; i < n && i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check_val({tag, "_beats"}, 32'(got_q.size()), 32'(n));
    check_val({tag, "_data"}, 32'(mism), 32'd0);
    check_val({tag, "_lasts"}, 32'(last_cnt), 32'(exp_last));
    if (exp_last > 0) begin
      check_val({tag, "_last_beat"}, 32'(last_beat), 32'(n));
      check_val({tag, "_err"}, 32'(last_err), 32'(exp_err));
      check_val({tag, "_code"}, 32'(last_code), 32'(exp_code));
    end
    check_val({tag, "_frame_ok"}, 32'(ok_cnt), 32'(exp_ok));
    check_val({tag, "_flag_rules"}, 32'(bad_cnt), 32'd0);
    $display("frame %s: beats=%0d lasts=%0d err=%0d code=%0d ok=%0d",
             tag, got_q.size(), last_cnt, last_err, last_code, ok_cnt);
  endtask

  initial begin
    logic [7:0] b;
    rst          = 1'b1;
    rx_if.CRS_DV = 1'b0;
    rx_if.RX0    = 1'b0;
    rx_if.RX1    = 1'b0;
    repeat (3) @(posedge clk_50MHz);
    #1;
    check_val("reset_outputs", 32'({rx_if.rx_data, rx_if.rx_valid, rx_if.rx_last, rx_if.rx_err,
                                    rx_if.rx_err_code, rx_if.frame_ok}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b00);

    // Minimum-length good frame after a 7x55 + D5 preamble.
    clear_mon();
    build_frame(60, 5);
    exp_q = frm;
    send_frame(31, -1, 0, 6);
    check_frame("t1_good64", 64, 1, 1'b0, 2'b00, 1);

    // Corrupted payload byte.
    clear_mon();
    build_frame(60, 5);
    frm[10] = frm[10] ^ 8'h01;
    exp_q = frm;
    send_frame(31, -1, 0, 6);
`ifdef RMII_RX_CRC_CHECK_EN
    check_frame("t2_crc_bad", 64, 1, 1'b1, 2'b01, 0);
`else
    check_frame("t2_crc_bad", 64, 1, 1'b0, 2'b00, 1);
`endif

    // Runt frames.
    clear_mon();
    build_frame(36, 9);
    exp_q = frm;
    send_frame(31, -1, 0, 6);
    check_frame("t3_runt40", 40, 1, 1'b1, 2'b10, 0);

    clear_mon();
    build_frame(59, 3);
    exp_q = frm;
    send_frame(31, -1, 0, 6);
    check_frame("t3_runt63", 63, 1, 1'b1, 2'b10, 0);

    // Oversize frame: truncated to MAX_FRAME_BYTES beats.
    clear_mon();
    build_frame(1996, 1);
    exp_q = frm;
    send_frame(31, -1, 0, 6);
    check_frame("t3_giant", 1518, 1, 1'b1, 2'b10, 0);

    // Trailing half byte.
    clear_mon();
    build_frame(60, 7);
    exp_q = frm;
    send_frame(31, -1, 2, 6);
    check_frame("t4_align", 64, 1, 1'b1, 2'b11, 0);

    // Single-clock carrier toggle inside the payload.
    clear_mon();
    build_frame(60, 5);
    exp_q = frm;
    send_frame(31, 20, 0, 6);
    check_frame("t4_toggle", 64, 1, 1'b0, 2'b00, 1);

    // Reset asserted at byte 30, rest of the frame still on the wire.
    clear_mon();
    build_frame(60, 11);
    for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 30; i++) begin
      b = frm[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
    @(posedge clk_50MHz);
    #1 rst = 1'b1;
    @(posedge clk_50MHz);
    #1 rst = 1'b0;
    check_val("t5_rst_outputs", 32'({rx_if.rx_data, rx_if.rx_valid, rx_if.rx_last, rx_if.rx_err,
                                     rx_if.rx_err_code, rx_if.frame_ok}), 32'd0);
    for (int i = 30; i < frm.size(); i++) begin
      b = frm[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
    for (int i = 0; i < 10; i++) drive(1'b0, 2'b00);
    check_val("t5_no_last", 32'(last_cnt), 32'd0);
    check_val("t5_no_ok", 32'(ok_cnt), 32'd0);
    clear_mon();
    build_frame(60, 13);
    exp_q = frm;
    send_frame(31, -1, 0, 6);
    check_frame("t5_after_rst", 64, 1, 1'b0, 2'b00, 1);

    // Preamble too short.
    clear_mon();
    build_frame(60, 2);
    exp_q = frm;
    send_frame(2, -1, 0, 6);
    check_frame("t6_short_pre", 0, 0, 1'b0, 2'b00, 0);

    // Back-to-back frames with a 2-clock gap.
    clear_mon();
    build_frame(60, 21);
    exp_q = frm;
    send_frame(31, -1, 0, 2);
    build_frame(62, 40);
    for (int i = 0; i < frm.size(); i++) exp_q.push_back(frm[i]);
    send_frame(31, -1, 0, 6);
    check_frame("t6_b2b", 130, 2, 1'b0, 2'b00, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
